// File: rtl/gs_mem_pkg.sv
// Shared types and sizes for the GS byte-wide to DDR3 64-bit memory bridge.
// The line buffer holds one 8-byte DDRAM word, and its tag is GS address bits [20:3].
package gs_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_REQ  = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_WR_REQ  = 2'd3
   } gs_mem_state_t;

   localparam int GS_LINE_BYTES = 8;
   localparam int GS_LINE_W     = 8 * GS_LINE_BYTES;
   localparam int GS_TAG_W      = 18;
   localparam int GS_ADDR_W     = 21;
   localparam int GS_DDR_AW     = 29;

endpackage

// File: rtl/gs_mem_bridge.sv
// Turns GS byte read/write strobes into single-beat 64-bit DDRAM transactions.
// A one-line read buffer serves sequential reads locally, and writes update it write-through.
module gs_mem_bridge
   import gs_mem_pkg::*;
#(
   parameter logic [GS_DDR_AW-1:0] BASE = 29'h0600000
)
(
   input  logic                   clk_mem,
   input  logic                   reset,
   input  logic [GS_ADDR_W-1:0]   addr,
   input  logic [7:0]             din,
   output logic [7:0]             dout,
   input  logic                   rd,
   input  logic                   we,
   output logic                   ready,
   output logic                   DDRAM_CLK,
   input  logic                   DDRAM_BUSY,
   output logic [7:0]             DDRAM_BURSTCNT,
   output logic [GS_DDR_AW-1:0]   DDRAM_ADDR,
   output logic                   DDRAM_RD,
   input  logic [GS_LINE_W-1:0]   DDRAM_DOUT,
   input  logic                   DDRAM_DOUT_READY,
   output logic [GS_LINE_W-1:0]   DDRAM_DIN,
   output logic [7:0]             DDRAM_BE,
   output logic                   DDRAM_WE
);

   gs_mem_state_t          state_q;
   logic                   ready_q;
   logic [7:0]             dout_q;
   logic                   ddr_rd_q;
   logic                   ddr_we_q;
   logic                   valid_q;

   logic [GS_ADDR_W-1:0]   addr_q;
   logic [7:0]             din_q;
   logic [7:0]             be_q;
   logic [GS_LINE_W-1:0]   line_q;
   logic [GS_TAG_W-1:0]    tag_q;

   logic                   hit_in;
   logic                   hit_lat;
   logic                   accept;

   function automatic logic [7:0] byte_sel(input logic [GS_LINE_W-1:0] l,
                                           input logic [2:0] idx);
      return l[{idx, 3'b000} +: 8];
   endfunction

   function automatic logic [GS_LINE_W-1:0] byte_merge(input logic [GS_LINE_W-1:0] l,
                                                       input logic [2:0] idx,
                                                       input logic [7:0] b);
      logic [GS_LINE_W-1:0] r;
      r = l;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

   assign hit_in  = valid_q && (tag_q == addr[GS_ADDR_W-1:3]);
   assign hit_lat = valid_q && (tag_q == addr_q[GS_ADDR_W-1:3]);
   assign accept  = (state_q == ST_IDLE) && (rd || we);

   always_ff @(posedge clk_mem or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ready_q  <= 1'b1;
         dout_q   <= 8'h00;
         ddr_rd_q <= 1'b0;
         ddr_we_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (we) begin
                  ddr_we_q <= 1'b1;
                  ready_q  <= 1'b0;
                  state_q  <= ST_WR_REQ;
               end else if (rd) begin
                  if (hit_in) begin
                     dout_q <= byte_sel(line_q, addr[2:0]);
                  end else begin
                     ddr_rd_q <= 1'b1;
                     ready_q  <= 1'b0;
                     state_q  <= ST_RD_REQ;
                  end
               end
            end
            ST_RD_REQ: begin
               if (!DDRAM_BUSY) begin
                  ddr_rd_q <= 1'b0;
                  state_q  <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (DDRAM_DOUT_READY) begin
                  valid_q <= 1'b1;
                  dout_q  <= byte_sel(DDRAM_DOUT, addr_q[2:0]);
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_WR_REQ: begin
               if (!DDRAM_BUSY) begin
                  ddr_we_q <= 1'b0;
                  ready_q  <= 1'b1;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Data-only registers: these need no reset because their contents are consumed only
   // after a strobe has been accepted or a line has been marked valid.
   always_ff @(posedge clk_mem) begin
      if (accept) begin
         addr_q <= addr;
         din_q  <= din;
         be_q   <= 8'h01 << addr[2:0];
      end
      if (state_q == ST_RD_WAIT && DDRAM_DOUT_READY) begin
         line_q <= DDRAM_DOUT;
         tag_q  <= addr_q[GS_ADDR_W-1:3];
      end else if (state_q == ST_WR_REQ && !DDRAM_BUSY && hit_lat) begin
         line_q <= byte_merge(line_q, addr_q[2:0], din_q);
      end
   end

   assign dout           = dout_q;
   assign ready          = ready_q;
   assign DDRAM_CLK      = clk_mem;
   assign DDRAM_BURSTCNT = 8'd1;
   assign DDRAM_ADDR     = BASE + {{(GS_DDR_AW-GS_TAG_W){1'b0}}, addr_q[GS_ADDR_W-1:3]};
   assign DDRAM_RD       = ddr_rd_q;
   assign DDRAM_DIN      = {GS_LINE_BYTES{din_q}};
   assign DDRAM_BE       = be_q;
   assign DDRAM_WE       = ddr_we_q;

endmodule
